// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALUop codes, mux selects and the control-word payload.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'b111;

    localparam logic [SEL_W-1:0] SRCB_REGB    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [SEL_W-1:0]   alu_src_b;
        logic [SEL_W-1:0]   pc_source;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: is_legal_op = 1'b1;
            default:                           is_legal_op = 1'b0;
        endcase
    endfunction

    // ALU operation for the immediate-arithmetic group.
    function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            OP_SLTI: imm_alu_op = ALU_SLT;
            default: imm_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_output_decoder.sv
// Moore decode of the control word from the current state; only the FETCH
// IR/PC loads follow mem_ready. Reset forces the whole word to zero.
module ctrl_output_decoder
    import mips_ctrl_pkg::*;
(
    input  logic                reset_i,
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [OPCODE_W-1:0] op_latch_i,
    input  logic                mem_ready_i,
    output ctrl_t               ctrl_o,
    output logic                illegal_op_o
);

    always_comb begin
        ctrl_o       = '0;
        illegal_op_o = 1'b0;
        if (!reset_i) begin
            case (state_i)
                ST_FETCH: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_b = SRCB_FOUR;
                    ctrl_o.ir_write  = mem_ready_i;
                    ctrl_o.pc_write  = mem_ready_i;
                end
                ST_DECODE: begin
                    ctrl_o.alu_src_b = SRCB_IMM_SH2;
                    illegal_op_o     = !is_legal_op(opcode_i);
                end
                ST_MEM_ADDR: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                end
                ST_MEM_RD: begin
                    ctrl_o.mem_read = 1'b1;
                    ctrl_o.iord     = 1'b1;
                end
                ST_MEM_WB: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.iord      = 1'b1;
                end
                ST_R_EXEC: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_REGB;
                    ctrl_o.alu_op    = ALU_RTYPE;
                end
                ST_R_WB: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.reg_dst   = 1'b1;
                end
                ST_I_EXEC: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    ctrl_o.alu_op    = imm_alu_op(op_latch_i);
                end
                ST_I_WB: begin
                    ctrl_o.reg_write = 1'b1;
                end
                ST_BRANCH: begin
                    ctrl_o.alu_src_a     = 1'b1;
                    ctrl_o.alu_src_b     = SRCB_REGB;
                    ctrl_o.alu_op        = ALU_SUB;
                    ctrl_o.pc_write_cond = 1'b1;
                    ctrl_o.pc_source     = PCSRC_ALUOUT;
                end
                ST_JUMP: begin
                    ctrl_o.pc_write  = 1'b1;
                    ctrl_o.pc_source = PCSRC_JUMP;
                end
                default: ctrl_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS datapath: state register, opcode
// latch, next-state logic and the retired-instruction counter.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [SEL_W-1:0]    pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired_cnt
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_latch_q;
    logic [CNT_W-1:0]    retired_cnt_q;
    logic                retire_c;
    ctrl_t               ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            op_latch_q    <= '0;
            retired_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_latch_q <= opcode;
            end
            if (retire_c) begin
                retired_cnt_q <= retired_cnt_q + CNT_W'(1);
            end
        end
    end

    // Next state; retire_c flags a completed instruction returning to FETCH.
    always_comb begin
        state_d  = ST_FETCH;
        retire_c = 1'b0;
        case (state_q)
            ST_FETCH:    state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:                            state_d = ST_R_EXEC;
                    OP_LW, OP_SW:                        state_d = ST_MEM_ADDR;
                    OP_BEQ:                              state_d = ST_BRANCH;
                    OP_J:                                state_d = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = ST_I_EXEC;
                    default:                             state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: state_d = (op_latch_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR: begin
                state_d  = mem_ready ? ST_FETCH : ST_MEM_WR;
                retire_c = mem_ready;
            end
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_I_EXEC:   state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: begin
                state_d  = ST_FETCH;
                retire_c = 1'b1;
            end
            default:     state_d = ST_FETCH;
        endcase
    end

    ctrl_output_decoder u_decoder (
        .reset_i      (reset),
        .state_i      (state_q),
        .opcode_i     (opcode),
        .op_latch_i   (op_latch_q),
        .mem_ready_i  (mem_ready),
        .ctrl_o       (ctrl),
        .illegal_op_o (illegal_op)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign retired_cnt   = retired_cnt_q;

endmodule
